hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_stat_counter.sv | 27 ++
 rtl/hazard_control_unit.sv | 147 ++++++++++++++
 tb/tb_hazard_control_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared definitions for the hazard control unit: the branch/jump opcode
//   encodings, the FSM state type and the width of the hold-cycle counter.
package hazard_pkg;

    // Width of the down-counter that tracks the remaining FLUSH/STALL cycles.
    localparam int CNT_W = 4;

    localparam logic [3:0] OP_BEQ = 4'b0011;
    localparam logic [3:0] OP_BNE = 4'b0100;
    localparam logic [3:0] OP_JMP = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_STALL = 2'd2
    } hazardState_t;

endpackage

// File: rtl/hazard_stat_counter.sv
// hazard_stat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk    - clock, rising edge
//     reset  - synchronous active-high reset, forces count to 0
//     clear  - synchronous clear, wins over inc
//     inc    - add one this cycle (ignored once count is all ones)
//     count  - current value
module hazard_stat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Pipeline hazard controller. A taken branch/jump in EX redirects the PC and
//   flushes ID/EX for FLUSH_CYCLES cycles; a load-use hazard between EX and ID
//   stalls IF/ID and bubbles EX for LOAD_STALL cycles. The first cycle of each
//   response is combinational from the EX/ID inputs; the remaining cycles are
//   driven by the FSM while its inputs are ignored.
//   Ports:
//     clk, reset             - clock, synchronous active-high reset
//     OpCode, zeroFlag       - EX opcode and ALU zero flag (branch decision)
//     memReadEX, rdEX        - EX instruction is a load, and its destination
//     rs1D, rs2D             - ID source registers
//     statClear              - synchronous clear of statCount
//     selectPCMux            - PC takes the branch target
//     stallF, stallD         - hold IF / ID registers
//     flushD, flushE         - bubble into ID / EX
//     stopSignal             - legacy alias of stallF
//     statCount              - saturating count of cycles with stallF|flushD
//     dbgState               - current FSM state, for observation only
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int OPCODE_W     = 4,
    parameter int REG_W        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int LOAD_STALL   = 1,
    parameter int STAT_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] OpCode,
    input  logic                zeroFlag,
    input  logic                memReadEX,
    input  logic [REG_W-1:0]    rdEX,
    input  logic [REG_W-1:0]    rs1D,
    input  logic [REG_W-1:0]    rs2D,
    input  logic                statClear,
    output logic                selectPCMux,
    output logic                stallF,
    output logic                stallD,
    output logic                flushD,
    output logic                flushE,
    output logic                stopSignal,
    output logic [STAT_W-1:0]   statCount,
    output hazardState_t        dbgState
);

    // The first hold cycle is the combinational IDLE cycle, so the counter is
    // loaded with (total - 2) and the FSM leaves on cnt == 0.
    localparam logic [CNT_W-1:0] FLUSH_INIT =
        CNT_W'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);
    localparam logic [CNT_W-1:0] STALL_INIT =
        CNT_W'((LOAD_STALL > 1) ? (LOAD_STALL - 2) : 0);

    hazardState_t     state;
    logic [CNT_W-1:0] cnt;
    logic             branchTaken;
    logic             loadUse;

    assign branchTaken = ((OpCode == OPCODE_W'(OP_BEQ)) &&  zeroFlag) ||
                         ((OpCode == OPCODE_W'(OP_BNE)) && !zeroFlag) ||
                          (OpCode == OPCODE_W'(OP_JMP));

    assign loadUse = memReadEX && (rdEX != '0) &&
                     ((rdEX == rs1D) || (rdEX == rs2D));

    // Control outputs; held at 0 while reset is high regardless of inputs.
    always_comb begin
        selectPCMux = 1'b0;
        stallF      = 1'b0;
        stallD      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    if (branchTaken) begin
                        selectPCMux = 1'b1;
                        flushD      = 1'b1;
                        flushE      = 1'b1;
                    end else if (loadUse) begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        flushE = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    flushD = 1'b1;
                    flushE = 1'b1;
                end
                ST_STALL: begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign stopSignal = stallF;
    assign dbgState   = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (branchTaken) begin
                        if (FLUSH_CYCLES > 1) begin
                            state <= ST_FLUSH;
                            cnt   <= FLUSH_INIT;
                        end
                    end else if (loadUse) begin
                        if (LOAD_STALL > 1) begin
                            state <= ST_STALL;
                            cnt   <= STALL_INIT;
                        end
                    end
                end
                ST_FLUSH, ST_STALL: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    hazard_stat_counter #(
        .W(STAT_W)
    ) u_statCounter (
        .clk   (clk),
        .reset (reset),
        .clear (statClear),
        .inc   (stallF | flushD),
        .count (statCount)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit. Two instances share the same stimulus:
//   instance 0: FLUSH_CYCLES=2, LOAD_STALL=3, STAT_W=3
//   instance 1: FLUSH_CYCLES=3, LOAD_STALL=4, STAT_W=16
// Each is compared every cycle against a model that tracks "cycles of flush
// or stall still owed" as plain integers.
module tb_hazard_control_unit;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] OpCode;
    logic       zeroFlag;
    logic       memReadEX;
    logic [3:0] rdEX, rs1D, rs2D;
    logic       statClear;

    logic [1:0]   sel, stF, stD, fD, fE, stop;
    logic [2:0]   statA;
    logic [15:0]  statB;
    hazardState_t stateA, stateB;

    int vecCount  = 0;
    int missCount = 0;

    // Model state per instance.
    int mFlushRem [2];
    int mStallRem [2];
    int mStat     [2];
    int pFlush    [2];
    int pStall    [2];
    int pStatMax  [2];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    hazard_control_unit #(
        .OPCODE_W(4), .REG_W(4), .FLUSH_CYCLES(2), .LOAD_STALL(3), .STAT_W(3)
    ) dutA (
        .clk(clk), .reset(reset), .OpCode(OpCode), .zeroFlag(zeroFlag),
        .memReadEX(memReadEX), .rdEX(rdEX), .rs1D(rs1D), .rs2D(rs2D),
        .statClear(statClear), .selectPCMux(sel[0]), .stallF(stF[0]),
        .stallD(stD[0]), .flushD(fD[0]), .flushE(fE[0]),
        .stopSignal(stop[0]), .statCount(statA), .dbgState(stateA)
    );

    hazard_control_unit #(
        .OPCODE_W(4), .REG_W(4), .FLUSH_CYCLES(3), .LOAD_STALL(4), .STAT_W(16)
    ) dutB (
        .clk(clk), .reset(reset), .OpCode(OpCode), .zeroFlag(zeroFlag),
        .memReadEX(memReadEX), .rdEX(rdEX), .rs1D(rs1D), .rs2D(rs2D),
        .statClear(statClear), .selectPCMux(sel[1]), .stallF(stF[1]),
        .stallD(stD[1]), .flushD(fD[1]), .flushE(fE[1]),
        .stopSignal(stop[1]), .statCount(statB), .dbgState(stateB)
    );

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: returns {sel, stall, flushD, flushE} for this cycle
    // and advances the owed-cycle bookkeeping.
    task automatic modelStep(input int k, output logic [3:0] exp);
        logic br, lu;
        br = ((OpCode == OP_BEQ) && zeroFlag) || ((OpCode == OP_BNE) && !zeroFlag) ||
             (OpCode == OP_JMP);
        lu = memReadEX && (rdEX != 0) && ((rdEX == rs1D) || (rdEX == rs2D));
        exp = 4'b0000;
        if (reset) begin
            mFlushRem[k] = 0;
            mStallRem[k] = 0;
        end else if (mFlushRem[k] > 0) begin
            exp = 4'b0011;
            mFlushRem[k]--;
        end else if (mStallRem[k] > 0) begin
            exp = 4'b0101;
            mStallRem[k]--;
        end else if (br) begin
            exp = 4'b1011;
            mFlushRem[k] = pFlush[k] - 1;
        end else if (lu) begin
            exp = 4'b0101;
            mStallRem[k] = pStall[k] - 1;
        end
        if (reset || statClear) mStat[k] = 0;
        else if ((exp[2] || exp[1]) && (mStat[k] < pStatMax[k])) mStat[k]++;
    endtask

    logic [3:0] lastExpA;

    // Driver: apply one cycle of inputs, compare both DUTs to the model.
    task automatic stepCycle(input logic r, input logic [3:0] op, input logic zf,
                             input logic mr, input logic [3:0] rd,
                             input logic [3:0] r1, input logic [3:0] r2,
                             input logic sc);
        logic [3:0] exp;
        logic [31:0] statAct;
        @(negedge clk);
        reset = r; OpCode = op; zeroFlag = zf; memReadEX = mr;
        rdEX = rd; rs1D = r1; rs2D = r2; statClear = sc;
        #1;
        for (int k = 0; k < 2; k++) begin
            statAct = (k == 0) ? 32'(statA) : 32'(statB);
            // statCount is registered: it reflects cycles before this one.
            check($sformatf("statCount[%0d]", k), statAct, 32'(mStat[k]));
            modelStep(k, exp);
            if (k == 0) lastExpA = exp;
            check($sformatf("selectPCMux[%0d]", k), 32'(sel[k]), 32'(exp[3]));
            check($sformatf("stallF[%0d]", k),      32'(stF[k]), 32'(exp[2]));
            check($sformatf("stallD[%0d]", k),      32'(stD[k]), 32'(exp[2]));
            check($sformatf("stopSignal[%0d]", k),  32'(stop[k]), 32'(exp[2]));
            check($sformatf("flushD[%0d]", k),      32'(fD[k]),  32'(exp[1]));
            check($sformatf("flushE[%0d]", k),      32'(fE[k]),  32'(exp[0]));
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       r;
        logic [3:0] op;
        logic       zf;
        logic       mr;
        logic [3:0] rd, r1, r2;
        logic       sc;
        logic [3:0] expA; // {sel, stall, flushD, flushE} for instance 0
    } vec_t;

    vec_t tbl [14];

    initial begin
        pFlush   = '{2, 3};
        pStall   = '{3, 4};
        pStatMax = '{7, 65535};
        mFlushRem = '{0, 0};
        mStallRem = '{0, 0};
        mStat     = '{0, 0};

        //          r   op     zf  mr  rd  r1  r2  sc  expA
        tbl[0]  = '{1, 4'h3, 1, 0, 0, 0, 0, 0, 4'b0000}; // reset beats BEQ taken
        tbl[1]  = '{1, 4'h3, 1, 0, 0, 0, 0, 0, 4'b0000};
        tbl[2]  = '{0, 4'h3, 1, 0, 0, 0, 0, 0, 4'b1011}; // BEQ taken
        tbl[3]  = '{0, 4'h3, 1, 0, 0, 0, 0, 0, 4'b0011}; // flush tail, input ignored
        tbl[4]  = '{0, 4'h4, 1, 0, 0, 0, 0, 0, 4'b0000}; // BNE not taken
        tbl[5]  = '{0, 4'h4, 0, 0, 0, 0, 0, 0, 4'b1011}; // BNE taken
        tbl[6]  = '{0, 4'h0, 0, 0, 0, 0, 0, 0, 4'b0011};
        tbl[7]  = '{0, 4'h0, 0, 1, 5, 0, 5, 0, 4'b0101}; // load-use on rs2
        tbl[8]  = '{0, 4'h0, 0, 0, 0, 0, 0, 0, 4'b0101};
        tbl[9]  = '{0, 4'h0, 0, 0, 0, 0, 0, 0, 4'b0101}; // third stall cycle
        tbl[10] = '{0, 4'h0, 0, 1, 0, 0, 0, 0, 4'b0000}; // rd = x0: no hazard
        tbl[11] = '{0, 4'h5, 0, 1, 5, 5, 0, 0, 4'b1011}; // JMP wins over load-use
        tbl[12] = '{0, 4'h0, 0, 0, 0, 0, 0, 0, 4'b0011};
        tbl[13] = '{0, 4'h0, 0, 0, 0, 0, 0, 0, 4'b0000};

        reset = 1'b1; OpCode = '0; zeroFlag = 1'b0; memReadEX = 1'b0;
        rdEX = '0; rs1D = '0; rs2D = '0; statClear = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 14; i++) begin
            stepCycle(tbl[i].r, tbl[i].op, tbl[i].zf, tbl[i].mr,
                      tbl[i].rd, tbl[i].r1, tbl[i].r2, tbl[i].sc);
            check($sformatf("table[%0d]", i),
                  32'({sel[0], stF[0], fD[0], fE[0]}), 32'(tbl[i].expA));
        end

        // Branch held 6 cycles from a cleared counter.
        stepCycle(0, 4'h0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) stepCycle(0, 4'h3, 1, 0, 0, 0, 0, 0);
        stepCycle(0, 4'h0, 0, 0, 0, 0, 0, 0);
        check("statCount six flush cycles [1]", 32'(statB), 32'd6);

        // Saturation on the 3-bit counter.
        stepCycle(0, 4'h0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) stepCycle(0, 4'h5, 0, 0, 0, 0, 0, 0);
        stepCycle(0, 4'h0, 0, 0, 0, 0, 0, 0);
        check("statCount saturated [0]", 32'(statA), 32'd7);
        repeat (3) stepCycle(0, 4'h0, 0, 0, 0, 0, 0, 0);
        check("statCount still saturated [0]", 32'(statA), 32'd7);
        stepCycle(0, 4'h5, 0, 0, 0, 0, 0, 1); // clear wins over increment
        stepCycle(0, 4'h0, 0, 0, 0, 0, 0, 0);
        check("statCount clear wins [0]", 32'(statA), 32'd0);
        repeat (4) stepCycle(0, 4'h0, 0, 0, 0, 0, 0, 0);

        // Reset during the second STALL cycle of instance 1 (LOAD_STALL=4).
        stepCycle(0, 4'h0, 0, 1, 7, 7, 0, 0); // load-use detected
        stepCycle(0, 4'h0, 0, 0, 0, 0, 0, 0); // first STALL cycle
        check("in STALL [1]", 32'(stateB), 32'(ST_STALL));
        stepCycle(1, 4'h3, 1, 1, 7, 7, 7, 0); // second STALL cycle, reset high
        check("outputs low under reset [1]",
              32'({sel[1], stF[1], fD[1], fE[1]}), 32'd0);
        stepCycle(0, 4'h0, 0, 0, 0, 0, 0, 0);
        check("state after reset [1]", 32'(stateB), 32'(ST_IDLE));
        check("outputs after reset [1]",
              32'({sel[1], stF[1], fD[1], fE[1]}), 32'd0);

        // Randomised traffic; registers drawn from a small set so hazards occur.
        for (int i = 0; i < 400; i++) begin
            stepCycle(($urandom_range(0, 39) == 0),
                      4'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 3)),
                      4'($urandom_range(0, 3)),
                      4'($urandom_range(0, 3)),
                      ($urandom_range(0, 29) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
